// File: rtl/seq_scan_ctrl_pkg.sv
// Shared constants for the serial pattern scanner: matched pattern and controller state codes.
// No logic; imported by the matcher and the controller.
package seq_scan_pkg;

    localparam int PAT_LEN = 11;
    localparam logic [PAT_LEN-1:0] PATTERN = 11'b11001010000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Bus-side bundle for seq_scan_ctrl: word handshake, run control and status/irq.
// master = word source / status logic, slave = controller.
interface seq_scan_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) ();

    logic              start;
    logic              stop;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic [CNT_W-1:0]  thresh;
    logic              irq_clr;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  match_count;
    logic              irq;

    modport master (
        output start, stop, in_valid, in_data, in_last, thresh, irq_clr,
        input  in_ready, busy, done, match_count, irq
    );

    modport slave (
        input  start, stop, in_valid, in_data, in_last, thresh, irq_clr,
        output in_ready, busy, done, match_count, irq
    );

endinterface

// File: rtl/seq_scan_ctrl_match_ce.sv
// Enable-gated serial matcher: hit is combinational on the presented bit, history updates at the edge.
// Keeps the last PAT_LEN-1 bits; hits only once a full pattern length has been seen since clear.
module seq_match_ce
    import seq_scan_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_ce,
    input  logic i_bit,
    output logic o_hit
);

    localparam int FILL_W = $clog2(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [PAT_LEN-1:0] w_win;

    assign w_win = {r_hist, i_bit};
    assign o_hit = i_ce && !i_clr && (w_win == PATTERN) && (r_fill == FILL_FULL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_ce) begin
            r_hist <= w_win[PAT_LEN-2:0];
            if (r_fill != FILL_FULL) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit stream controller feeding seq_match_ce; first bit reaches the matcher the cycle after accept.
// in_ready in WAIT and the final shift cycle (zero-bubble streaming), dropped while stop is asserted.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input logic           clk,
    input logic           reset,
    seq_scan_ctrl_if.slave bus
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [BIT_W-1:0]  r_bit;
    logic              r_last;
    logic [CNT_W-1:0]  r_count;
    logic              r_irq;

    logic             w_final;
    logic             w_ready;
    logic             w_accept;
    logic             w_start;
    logic             w_stop;
    logic             w_ce;
    logic             w_hit;
    logic             w_inc;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_final     = (r_state == S_SHIFT) && (r_bit == LAST_BIT);
    assign w_ready     = ((r_state == S_WAIT) || w_final) && !bus.stop;
    assign w_accept    = bus.in_valid && w_ready;
    assign w_stop      = bus.stop && ((r_state == S_WAIT) || (r_state == S_SHIFT));
    assign w_start     = bus.start && !bus.stop && (r_state == S_IDLE);
    assign w_ce        = (r_state == S_SHIFT) && !bus.stop;
    assign w_inc       = w_hit && (r_count != CNT_MAX);
    assign w_count_nxt = r_count + 1'b1;

    seq_match_ce u_match (
        .clk   (clk),
        .reset (reset),
        .i_clr (w_start || w_stop),
        .i_ce  (w_ce),
        .i_bit (r_shift[DATA_W-1]),
        .o_hit (w_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start) r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.stop)      r_state <= S_IDLE;
                    else if (w_accept) r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (bus.stop)                r_state <= S_IDLE;
                    else if (w_final && !w_accept) r_state <= r_last ? S_DONE : S_WAIT;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_bit   <= '0;
            r_last  <= 1'b0;
        end else if (w_accept) begin
            r_shift <= bus.in_data;
            r_bit   <= '0;
            r_last  <= bus.in_last;
        end else if (w_stop) begin
            r_bit   <= '0;
        end else if (w_ce) begin
            r_shift <= r_shift << 1;
            r_bit   <= w_final ? '0 : r_bit + 1'b1;
        end
    end

    // irq set takes precedence over a coincident irq_clr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_irq   <= 1'b0;
        end else if (w_start) begin
            r_count <= '0;
            r_irq   <= 1'b0;
        end else begin
            if (w_inc) begin
                r_count <= w_count_nxt;
            end
            if (w_inc && (bus.thresh != '0) && (w_count_nxt == bus.thresh)) begin
                r_irq <= 1'b1;
            end else if (bus.irq_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = w_ready;
    assign bus.busy        = (r_state == S_WAIT) || (r_state == S_SHIFT);
    assign bus.done        = (r_state == S_DONE);
    assign bus.match_count = r_count;
    assign bus.irq         = r_irq;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: two instances (CNT_W=8 and CNT_W=2) see the same stimulus;
// a bit-level model predicts count/irq change cycles and done cycles, and a negedge monitor compares.
module tb_seq_scan_ctrl;

    localparam int DW = 8;
    localparam logic [10:0] PAT = 11'b11001010000;

    typedef struct {
        int cyc;
        int cnt0;
        int cnt1;
        bit irq0;
        bit irq1;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          tb_start, tb_stop, tb_valid, tb_last, tb_irq_clr;
    logic [DW-1:0] tb_data;
    logic [7:0]    tb_thr;
    logic [1:0]    tb_thr_s;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    ev_t evq[$];
    int  dq[$];
    ev_t mon_ev;
    int  m_cnt[2];
    bit  m_irq[2];
    int  m_thr[2];
    int  m_max[2];
    int  c_cnt[2];
    bit  c_irq[2];
    logic [9:0] m_hist;
    int  m_nbits;
    int  prev0, prev1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_scan_ctrl_if #(.DATA_W(DW), .CNT_W(8)) bus ();
    seq_scan_ctrl_if #(.DATA_W(DW), .CNT_W(2)) bus_s ();

    assign bus.start    = tb_start;    assign bus_s.start    = tb_start;
    assign bus.stop     = tb_stop;     assign bus_s.stop     = tb_stop;
    assign bus.in_valid = tb_valid;    assign bus_s.in_valid = tb_valid;
    assign bus.in_data  = tb_data;     assign bus_s.in_data  = tb_data;
    assign bus.in_last  = tb_last;     assign bus_s.in_last  = tb_last;
    assign bus.irq_clr  = tb_irq_clr;  assign bus_s.irq_clr  = tb_irq_clr;
    assign bus.thresh   = tb_thr;      assign bus_s.thresh   = tb_thr_s;

    seq_scan_ctrl #(.DATA_W(DW), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    seq_scan_ctrl #(.DATA_W(DW), .CNT_W(2)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = '{0, 0};
        m_irq = '{0, 0};
        c_cnt = '{0, 0};
        c_irq = '{0, 0};
        m_hist = '0;
        m_nbits = 0;
    endtask

    // Word accepted at the edge that makes cyc == e; bit DW-1 is presented during cycle e.
    task automatic model_accept(input logic [DW-1:0] d, input logic last, input int e);
        logic [10:0] win;
        ev_t ev;
        for (int i = DW - 1; i >= 0; i--) begin
            win = {m_hist, d[i]};
            m_hist = win[9:0];
            m_nbits++;
            if (win == PAT && m_nbits >= 11) begin
                for (int k = 0; k < 2; k++) begin
                    if (m_cnt[k] < m_max[k]) begin
                        m_cnt[k]++;
                        if (m_thr[k] != 0 && m_cnt[k] == m_thr[k]) m_irq[k] = 1'b1;
                    end
                end
                ev.cyc  = e + (DW - 1 - i) + 1;
                ev.cnt0 = m_cnt[0];
                ev.cnt1 = m_cnt[1];
                ev.irq0 = m_irq[0];
                ev.irq1 = m_irq[1];
                evq.push_back(ev);
            end
        end
        if (last) dq.push_back(e + DW);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (evq.size() > 0 && evq[0].cyc < cyc) begin
                chk("ev_missed", cyc, evq[0].cyc);
                evq.delete(0);
            end
            if (evq.size() > 0 && evq[0].cyc == cyc) begin
                mon_ev = evq.pop_front();
                chk("sb_cnt", bus.match_count, mon_ev.cnt0);
                chk("sb_cnt_s", bus_s.match_count, mon_ev.cnt1);
                chk("sb_irq", bus.irq, mon_ev.irq0);
                chk("sb_irq_s", bus_s.irq, mon_ev.irq1);
                c_cnt = '{mon_ev.cnt0, mon_ev.cnt1};
                c_irq = '{mon_ev.irq0, mon_ev.irq1};
            end else begin
                if (bus.match_count != prev0) chk("cnt_spurious", bus.match_count, prev0);
                if (bus_s.match_count != prev1) chk("cnt_s_spurious", bus_s.match_count, prev1);
            end
            if (dq.size() > 0 && dq[0] == cyc) begin
                void'(dq.pop_front());
                chk("done", bus.done, 1);
                chk("done_s", bus_s.done, 1);
                chk("busy_at_done", bus.busy, 0);
            end else if (bus.done || bus_s.done) begin
                chk("done_spurious", {bus.done, bus_s.done}, 0);
            end
        end
        prev0 = bus.match_count;
        prev1 = bus_s.match_count;
    end

    task automatic set_thr(input int t);
        tb_thr   = 8'(t);
        tb_thr_s = 2'(t);
        m_thr    = '{t, t};
    endtask

    task automatic start_run();
        ev_t ev;
        tb_start = 1'b1;
        model_reset();
        ev.cyc = cyc + 1;
        ev.cnt0 = 0;
        ev.cnt1 = 0;
        ev.irq0 = 1'b0;
        ev.irq1 = 1'b0;
        evq.push_back(ev);
        @(posedge clk); #1;
        tb_start = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last, output int waits);
        bit acc = 1'b0;
        tb_valid = 1'b1;
        tb_data  = d;
        tb_last  = last;
        waits    = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            waits++;
            if (bus.in_ready) begin
                acc = 1'b1;
                model_accept(d, last, cyc + 1);
                break;
            end
        end
        chk("accept", acc, 1);
        @(posedge clk); #1;
        tb_valid = 1'b0;
        tb_last  = 1'b0;
    endtask

    task automatic stop_now();
        int s = cyc;
        tb_stop = 1'b1;
        while (evq.size() > 0 && evq[$].cyc > s) evq.delete(evq.size() - 1);
        while (dq.size() > 0 && dq[$] > s) dq.delete(dq.size() - 1);
        if (evq.size() > 0) begin
            m_cnt = '{evq[$].cnt0, evq[$].cnt1};
            m_irq = '{evq[$].irq0, evq[$].irq1};
        end else begin
            m_cnt = c_cnt;
            m_irq = c_irq;
        end
        m_hist = '0;
        m_nbits = 0;
        @(posedge clk); #1;
        tb_stop = 1'b0;
    endtask

    task automatic irq_clr_pulse();
        tb_irq_clr = 1'b1;
        for (int i = 0; i < evq.size(); i++) begin
            if (evq[i].cyc > cyc + 1) begin
                evq[i].irq0 = 1'b0;
                evq[i].irq1 = 1'b0;
            end
        end
        m_irq = '{0, 0};
        c_irq = '{0, 0};
        @(posedge clk); #1;
        tb_irq_clr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, seen, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int w;
        bit saw_done;
        reset = 1'b1;
        tb_start = 1'b0; tb_stop = 1'b0; tb_valid = 1'b0; tb_last = 1'b0; tb_irq_clr = 1'b0;
        tb_data = '0;
        m_max = '{255, 3};
        set_thr(0);
        model_reset();
        repeat (2) @(posedge clk); #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_cnt", bus.match_count, 0);
        chk("rst_irq", bus.irq, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: back-to-back words, single hit spanning the word boundary
        start_run();
        chk("t1_busy", bus.busy, 1);
        send_word(8'hCA, 1'b0, w);
        chk("t1_first_wait", w, 1);
        send_word(8'h00, 1'b1, w);
        chk("t1_no_bubble", w, DW);
        wait_done("t1_done_seen");
        chk("t1_busy_after", bus.busy, 0);
        chk("t1_cnt", bus.match_count, 1);

        // 2: threshold irq and clear
        set_thr(2);
        start_run();
        fork
            begin
                send_word(8'hCA, 1'b0, w);
                send_word(8'h00, 1'b0, w);
                send_word(8'hCA, 1'b0, w);
                send_word(8'h00, 1'b1, w);
            end
            begin
                bit seen = 1'b0;
                for (int n = 0; n < 200; n++) begin
                    @(negedge clk);
                    if (bus.irq) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("t2_irq_rise", seen, 1);
                chk("t2_cnt_at_irq", bus.match_count, 2);
                @(posedge clk); #1;
                irq_clr_pulse();
                @(negedge clk);
                chk("t2_irq_clr", bus.irq, 0);
                chk("t2_irq_clr_s", bus_s.irq, 0);
                chk("t2_cnt_hold", bus.match_count, 2);
            end
        join
        wait_done("t2_done_seen");
        chk("t2_cnt_end", bus.match_count, 2);

        // 3: gap in WAIT keeps history; start while busy is ignored
        set_thr(0);
        start_run();
        send_word(8'hCA, 1'b0, w);
        repeat (DW) @(posedge clk);
        #1;
        chk("t3_wait_ready", bus.in_ready, 1);
        tb_start = 1'b1;
        @(posedge clk); #1;
        tb_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        send_word(8'h00, 1'b1, w);
        wait_done("t3_done_seen");
        chk("t3_cnt", bus.match_count, 1);

        // 4: stop mid-shift discards word and history; start+stop in IDLE stays idle
        start_run();
        send_word(8'hCA, 1'b0, w);
        send_word(8'h00, 1'b0, w);
        @(posedge clk); #1;
        stop_now();
        @(negedge clk);
        chk("t4_stop_idle", bus.busy, 0);
        chk("t4_stop_cnt", bus.match_count, 0);
        @(posedge clk); #1;
        tb_start = 1'b1;
        tb_stop  = 1'b1;
        @(posedge clk); #1;
        tb_start = 1'b0;
        tb_stop  = 1'b0;
        chk("t4_start_stop_idle", bus.busy, 0);
        start_run();
        send_word(8'h00, 1'b1, w);
        wait_done("t4_done_seen");
        chk("t4_cnt_cleared_hist", bus.match_count, 0);

        // 6: saturation of the narrow counter
        set_thr(3);
        start_run();
        for (int p = 0; p < 4; p++) begin
            send_word(8'hCA, 1'b0, w);
            send_word(8'h00, (p == 3), w);
        end
        wait_done("t6_done_seen");
        chk("t6_cnt", bus.match_count, 4);
        chk("t6_cnt_sat", bus_s.match_count, 3);
        chk("t6_irq", bus.irq, 1);
        chk("t6_irq_s", bus_s.irq, 1);

        // 5: asynchronous reset mid-shift
        set_thr(1);
        start_run();
        send_word(8'hCA, 1'b0, w);
        send_word(8'h00, 1'b0, w);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_pre_busy", bus.busy, 1);
        chk("t5_pre_cnt", bus.match_count, 1);
        chk("t5_pre_irq", bus.irq, 1);
        reset = 1'b1;
        #1;
        chk("t5_rst_busy", bus.busy, 0);
        chk("t5_rst_ready", bus.in_ready, 0);
        chk("t5_rst_cnt", bus.match_count, 0);
        chk("t5_rst_irq", bus.irq, 0);
        chk("t5_rst_cnt_s", bus_s.match_count, 0);
        evq.delete();
        dq.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        chk("t5_no_done", saw_done, 0);
        chk("t5_idle", bus.busy, 0);

        chk("evq_drained", evq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
